// File: rtl/issue_pkg.sv
// Shared definitions for the instruction issue sequencer: state encoding,
// instruction width and the canonical RISC-V NOP.
package issue_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERROR = 2'd3
    } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with a show-ahead head; push is refused when full and pop
// is ignored when empty, so callers may drive them without extra gating.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd];
    assign count  = r_cnt;

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Buffers host instruction words and issues them to the core one at a time,
// waiting for completion, with a watchdog and statistics counters.
module instr_issue_sequencer
    import issue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_W-1:0]     hostInstruction,
    input  logic                   hostValid,
    output logic                   hostReady,
    input  logic                   enable,
    input  logic                   clearError,
    output logic [INSTR_W-1:0]     instruction,
    output logic                   validInstruction,
    input  logic                   completeInstruction,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifoCount,
    output logic [31:0]            issuedCount,
    output logic [31:0]            completedCount,
    output logic [31:0]            stallCycles,
    output logic                   timeoutError
);

    localparam int WCW = $clog2(TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    logic [WCW-1:0]       r_waitCnt;
    logic [INSTR_W-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_canIssue;
    logic                 w_issue;
    logic                 w_complete;
    logic                 w_stall;
    logic                 w_timeout;
    logic                 w_clrErr;

    instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hostValid),
        .pop   (w_issue),
        .din   (hostInstruction),
        .dout  (w_head),
        .count (fifoCount),
        .full  (w_full),
        .empty (w_empty)
    );

    assign hostReady  = ~w_full;
    assign busy       = (r_state == ISSUE) || (r_state == WAIT);
    assign w_canIssue = ~w_empty & enable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        w_complete = 1'b0;
        w_stall    = 1'b0;
        w_timeout  = 1'b0;
        w_clrErr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_canIssue) begin
                    w_issue = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (completeInstruction) begin
                    w_complete = 1'b1;
                    if (w_canIssue) begin
                        w_issue = 1'b1;
                        w_next  = ISSUE;
                    end else begin
                        w_next  = IDLE;
                    end
                end else begin
                    w_stall = 1'b1;
                    if (r_waitCnt == WAIT_LAST) begin
                        w_timeout = 1'b1;
                        w_next    = ERROR;
                    end
                end
            end
            ERROR: begin
                if (clearError) begin
                    w_clrErr = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction      <= '0;
            validInstruction <= 1'b0;
            issuedCount      <= '0;
            completedCount   <= '0;
            stallCycles      <= '0;
            timeoutError     <= 1'b0;
            r_waitCnt        <= '0;
        end else begin
            validInstruction <= w_issue;
            if (w_issue) instruction <= w_head;
            issuedCount    <= issuedCount + 32'(w_issue);
            completedCount <= completedCount + 32'(w_complete);
            stallCycles    <= stallCycles + 32'(w_stall);
            // The watchdog window restarts on every issue.
            if (r_state == ISSUE) r_waitCnt <= '0;
            else if (w_stall)     r_waitCnt <= r_waitCnt + 1'b1;
            if (w_timeout)        timeoutError <= 1'b1;
            else if (w_clrErr)    timeoutError <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Directed bench for instr_issue_sequencer with hand-computed expectations.
module tb_instr_issue_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] hostInstruction = '0;
    logic        hostValid = 1'b0;
    logic        hostReady;
    logic        enable = 1'b0;
    logic        clearError = 1'b0;
    logic [31:0] instruction;
    logic        validInstruction;
    logic        completeInstruction = 1'b0;
    logic        busy;
    logic [3:0]  fifoCount;
    logic [31:0] issuedCount, completedCount, stallCycles;
    logic        timeoutError;

    instr_issue_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .hostInstruction     (hostInstruction),
        .hostValid           (hostValid),
        .hostReady           (hostReady),
        .enable              (enable),
        .clearError          (clearError),
        .instruction         (instruction),
        .validInstruction    (validInstruction),
        .completeInstruction (completeInstruction),
        .busy                (busy),
        .fifoCount           (fifoCount),
        .issuedCount         (issuedCount),
        .completedCount      (completedCount),
        .stallCycles         (stallCycles),
        .timeoutError        (timeoutError)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Every issue pulse seen by the core, with the cycle it appeared in.
    logic [31:0] pq[$];
    int          pc[$];
    always @(negedge clk) begin
        if (validInstruction) begin
            pq.push_back(instruction);
            pc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        hostValid       = 1'b1;
        hostInstruction = w;
        step();
        hostValid       = 1'b0;
    endtask

    initial begin
        logic [31:0] w;

        // Reset state
        #2;
        chk("rst_ready", hostReady, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifoCount, 0);
        chk("rst_valid", validInstruction, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_issued", issuedCount, 0);
        chk("rst_tmo", timeoutError, 0);
        step();
        reset = 1'b1;
        step();

        // Single issue, completion 3 cycles after the pulse
        enable = 1'b1;
        pq.delete(); pc.delete();
        push(32'h000000B3);
        chk("s_count1", fifoCount, 1);
        chk("s_valid0", validInstruction, 0);
        step();
        chk("s_valid1", validInstruction, 1);
        chk("s_instr", instruction, 32'h000000B3);
        chk("s_count0", fifoCount, 0);
        chk("s_issued", issuedCount, 1);
        chk("s_busy", busy, 1);
        step();
        chk("s_valid_drop", validInstruction, 0);
        step(2);
        completeInstruction = 1'b1;
        step();
        completeInstruction = 1'b0;
        chk("s_completed", completedCount, 1);
        chk("s_stall", stallCycles, 2);
        chk("s_idle", busy, 0);
        chk("s_pulses", pq.size(), 1);

        // Fill and order
        enable = 1'b0;
        pq.delete(); pc.delete();
        for (int i = 0; i < 9; i++) begin
            w = 32'h1000_0000 + 32'(i);
            push(w);
            if (i == 7) chk("f_ready_full", hostReady, 0);
        end
        chk("f_count8", fifoCount, 8);
        completeInstruction = 1'b1;
        enable = 1'b1;
        step(17);
        completeInstruction = 1'b0;
        chk("f_pulses", pq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            w = 32'h1000_0000 + 32'(i);
            chk($sformatf("f_order%0d", i), pq[i], w);
            if (i > 0) chk($sformatf("f_space%0d", i), pc[i] - pc[i-1], 2);
        end
        chk("f_count0", fifoCount, 0);
        chk("f_issued", issuedCount, 9);
        chk("f_completed", completedCount, 9);
        chk("f_stall", stallCycles, 2);

        // Simultaneous push and pop
        enable = 1'b0;
        pq.delete(); pc.delete();
        push(32'hA);
        push(32'hB);
        push(32'hC);
        chk("p_count3", fifoCount, 3);
        enable = 1'b1;
        push(32'hD);
        chk("p_count_same", fifoCount, 3);
        chk("p_first", instruction, 32'hA);
        completeInstruction = 1'b1;
        step(8);
        completeInstruction = 1'b0;
        chk("p_pulses", pq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("p_order%0d", i), pq[i], 32'hA + 32'(i));
        chk("p_completed", completedCount, 13);

        // Timeout
        enable = 1'b0;
        pq.delete(); pc.delete();
        push(32'hE);
        push(32'hF);
        enable = 1'b1;
        step(2);
        step(63);
        chk("t_not_yet", timeoutError, 0);
        chk("t_busy_wait", busy, 1);
        step();
        chk("t_error", timeoutError, 1);
        chk("t_busy_err", busy, 0);
        chk("t_stall", stallCycles, 66);
        completeInstruction = 1'b1;
        step(3);
        completeInstruction = 1'b0;
        chk("t_cmp_ignored", completedCount, 13);
        chk("t_no_pulse", pq.size(), 1);
        chk("t_fifo_kept", fifoCount, 1);
        chk("t_sticky", timeoutError, 1);
        clearError = 1'b1;
        step();
        clearError = 1'b0;
        chk("t_cleared", timeoutError, 0);
        step();
        chk("t_reissue_v", validInstruction, 1);
        chk("t_reissue_i", instruction, 32'hF);
        step();
        completeInstruction = 1'b1;
        step();
        completeInstruction = 1'b0;
        chk("t_completed", completedCount, 14);
        chk("t_issued", issuedCount, 15);

        // Pause during WAIT
        enable = 1'b0;
        pq.delete(); pc.delete();
        push(32'h100);
        push(32'h200);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step();
        completeInstruction = 1'b1;
        step();
        completeInstruction = 1'b0;
        chk("u_completed", completedCount, 15);
        step(3);
        chk("u_held", pq.size(), 1);
        chk("u_count", fifoCount, 1);
        chk("u_idle", busy, 0);
        enable = 1'b1;
        step();
        chk("u_resume", instruction, 32'h200);
        chk("u_issued", issuedCount, 17);
        step();
        completeInstruction = 1'b1;
        step();
        completeInstruction = 1'b0;
        chk("u_stall", stallCycles, 67);

        // Reset mid-WAIT with 3 words queued
        enable = 1'b0;
        pq.delete(); pc.delete();
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i));
        enable = 1'b1;
        step(2);
        chk("r_queued", fifoCount, 3);
        chk("r_inwait", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_count", fifoCount, 0);
        chk("r_busy", busy, 0);
        chk("r_ready", hostReady, 1);
        chk("r_instr", instruction, 0);
        chk("r_issued", issuedCount, 0);
        chk("r_stall", stallCycles, 0);
        step();
        reset = 1'b1;
        pq.delete(); pc.delete();
        step(4);
        chk("r_no_pulse", pq.size(), 0);
        push(32'h555);
        step();
        chk("r_new_v", validInstruction, 1);
        chk("r_new_i", instruction, 32'h555);
        chk("r_new_cnt", issuedCount, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
